// File: rtl/ram_bank_demux.sv
// OBI bank demultiplexer: routes one master port to two SRAM banks by the top
// in-range address bit and returns responses in order via a bank-ID FIFO.
package ram_bank_demux_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module ram_bank_demux
  import ram_bank_demux_pkg::*;
#(
  parameter int unsigned NUM_BYTES       = 2**16,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned AddrWidth      = $clog2(NUM_BYTES),
  localparam int unsigned CntWidth       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  obi_req_t            master_req_i,
  output obi_resp_t           master_resp_o,
  output obi_req_t            ram0_req_o,
  input  obi_resp_t           ram0_resp_i,
  output obi_req_t            ram1_req_o,
  input  obi_resp_t           ram1_resp_i,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                order_err_o
);

  // Pointers keep at least one bit so a depth-1 FIFO still has a legal index.
  localparam int unsigned PtrWidth = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned Depth    = 2**PtrWidth;

  logic [Depth-1:0]    fifo_q;
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic                order_err_q;

  logic        sel;
  logic        full;
  logic        empty;
  logic        head;
  logic        sel_gnt;
  logic        head_rvalid;
  logic [31:0] head_rdata;
  logic        push;
  logic        pop;
  logic        stray;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MAX_OUTSTANDING - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign sel         = master_req_i.addr[AddrWidth-1];
  assign full        = (count_q == CntWidth'(MAX_OUTSTANDING));
  assign empty       = (count_q == '0);
  assign head        = fifo_q[rd_ptr_q];
  assign sel_gnt     = sel  ? ram1_resp_i.gnt    : ram0_resp_i.gnt;
  assign head_rvalid = head ? ram1_resp_i.rvalid : ram0_resp_i.rvalid;
  assign head_rdata  = head ? ram1_resp_i.rdata  : ram0_resp_i.rdata;

  // A grant is exactly a bank acceptance: the bank only sees req when not full.
  assign push = master_req_i.req & ~full & sel_gnt;
  assign pop  = ~empty & head_rvalid;

  // Any rvalid that is not the head bank's answer is a protocol violation.
  assign stray = empty ? (ram0_resp_i.rvalid | ram1_resp_i.rvalid)
                       : (head ? ram0_resp_i.rvalid : ram1_resp_i.rvalid);

  // NOTE: every output of this block gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ram0_req_o     = master_req_i;
    ram1_req_o     = master_req_i;
    ram0_req_o.req = master_req_i.req & ~sel & ~full;
    ram1_req_o.req = master_req_i.req &  sel & ~full;

    master_resp_o        = '0;
    master_resp_o.gnt    = push;
    master_resp_o.rvalid = pop;
    master_resp_o.rdata  = pop ? head_rdata : 32'h0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      order_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
      if (stray) order_err_q <= 1'b1;
    end
  end

  // NOTE: the entry storage is deliberately not reset; an entry is only read
  // after it was written, because the occupancy count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= sel;
  end

  assign outstanding_o = count_q;
  assign order_err_o   = order_err_q;

endmodule

// File: tb/tb_ram_bank_demux.sv
// Self-checking bench: two demux instances (depth 2 and depth 1) driving stub
// 1-cycle SRAM banks, checked against an address-level memory/queue model.
`timescale 1ns/1ps
module tb_ram_bank_demux;
  import ram_bank_demux_pkg::*;

  localparam int NB = 2**16;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Master stimulus and DUT-side signals
  obi_req_t  m_req [2];
  obi_resp_t d0_mresp, d1_mresp;
  obi_req_t  d0_r0, d0_r1, d1_r0, d1_r1;
  obi_resp_t d0_b0, d0_b1, d1_b0, d1_b1;
  logic [1:0] d0_out;
  logic [0:0] d1_out;
  logic       d0_err, d1_err;

  // Stub banks, index = dut*2 + bank
  obi_req_t    bq [4];
  obi_resp_t   bs [4];
  logic        bgnt [4];
  logic        hold [4];
  logic        inj  [4];
  logic        pend [4];
  logic [31:0] brd  [4];
  logic [31:0] bmem [4][256] = '{default: '0};

  ram_bank_demux #(.NUM_BYTES(NB), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .master_req_i(m_req[0]), .master_resp_o(d0_mresp),
    .ram0_req_o(d0_r0), .ram0_resp_i(d0_b0),
    .ram1_req_o(d0_r1), .ram1_resp_i(d0_b1),
    .outstanding_o(d0_out), .order_err_o(d0_err)
  );

  ram_bank_demux #(.NUM_BYTES(NB), .MAX_OUTSTANDING(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .master_req_i(m_req[1]), .master_resp_o(d1_mresp),
    .ram0_req_o(d1_r0), .ram0_resp_i(d1_b0),
    .ram1_req_o(d1_r1), .ram1_resp_i(d1_b1),
    .outstanding_o(d1_out), .order_err_o(d1_err)
  );

  always_comb begin
    bq[0] = d0_r0; bq[1] = d0_r1; bq[2] = d1_r0; bq[3] = d1_r1;
    for (int b = 0; b < 4; b++) begin
      bs[b].gnt    = bgnt[b];
      bs[b].rvalid = (pend[b] & ~hold[b]) | inj[b];
      bs[b].rdata  = brd[b];
    end
  end
  assign d0_b0 = bs[0];
  assign d0_b1 = bs[1];
  assign d1_b0 = bs[2];
  assign d1_b1 = bs[3];

  // Stub SRAM: accepted request answered next cycle unless held back.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < 4; b++) pend[b] <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (pend[b] && !hold[b]) pend[b] <= 1'b0;
        if (bq[b].req && bgnt[b]) begin
          pend[b] <= 1'b1;
          if (bq[b].we) begin
            for (int k = 0; k < 4; k++)
              if (bq[b].be[k]) bmem[b][bq[b].addr[9:2]][8*k +: 8] <= bq[b].wdata[8*k +: 8];
            brd[b] <= 32'h0;
          end else begin
            brd[b] <= bmem[b][bq[b].addr[9:2]];
          end
        end
      end
    end
  end

  // Reference model: per-DUT byte-addressed memory image and queue of
  // expected responses ({is_write, rdata}) in grant order.
  logic [31:0] ref_mem [2][2][256] = '{default: '0};
  logic [32:0] exp_q [2][$];
  logic        prev_gnt [2];
  logic        mon_en   [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic monitor(input int d);
    obi_req_t    mq, r0, r1;
    obi_resp_t   mr;
    logic        err, bank, exp_gnt, room;
    int          outst, cap, occ, w;
    logic [32:0] e;
    mq = m_req[d];
    if (d == 0) begin
      mr = d0_mresp; r0 = d0_r0; r1 = d0_r1; outst = int'(d0_out); err = d0_err; cap = 2;
    end else begin
      mr = d1_mresp; r0 = d1_r0; r1 = d1_r1; outst = int'(d1_out); err = d1_err; cap = 1;
    end
    occ = exp_q[d].size();
    check($sformatf("d%0d_outstanding", d), outst, occ);
    check($sformatf("d%0d_rvalid", d), mr.rvalid, prev_gnt[d]);
    check($sformatf("d%0d_order_err", d), err, 0);
    if (mr.rvalid && occ > 0) begin
      e = exp_q[d].pop_front();
      if (!e[32]) check($sformatf("d%0d_rdata", d), mr.rdata, e[31:0]);
    end else begin
      check($sformatf("d%0d_rdata_idle", d), mr.rdata, 0);
    end
    bank    = ((mq.addr % NB) >= NB/2);
    w       = int'(((mq.addr % NB) % (NB/2)) / 4) % 256;
    room    = (occ < cap);
    exp_gnt = mq.req && room && (bank ? bgnt[2*d+1] : bgnt[2*d]);
    check($sformatf("d%0d_gnt", d), mr.gnt, exp_gnt);
    check($sformatf("d%0d_ram0_req", d), r0.req, mq.req && !bank && room);
    check($sformatf("d%0d_ram1_req", d), r1.req, mq.req &&  bank && room);
    check($sformatf("d%0d_fwd_addr", d), r0.addr, mq.addr);
    check($sformatf("d%0d_fwd_wdata", d), r1.wdata, mq.wdata);
    if (exp_gnt) begin
      if (mq.we) begin
        for (int k = 0; k < 4; k++)
          if (mq.be[k]) ref_mem[d][bank][w][8*k +: 8] = mq.wdata[8*k +: 8];
        exp_q[d].push_back({1'b1, 32'h0});
      end else begin
        exp_q[d].push_back({1'b0, ref_mem[d][bank][w]});
      end
    end
    prev_gnt[d] = exp_gnt;
  endtask

  task automatic sample();
    @(negedge clk_i);
    if (rst_i) begin
      for (int d = 0; d < 2; d++) begin
        exp_q[d].delete();
        prev_gnt[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) if (mon_en[d]) monitor(d);
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int d, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    m_req[d].req   = req;
    m_req[d].we    = we;
    m_req[d].be    = 4'hF;
    m_req[d].addr  = addr;
    m_req[d].wdata = wdata;
  endtask

  task automatic write_word(input int d, input logic [31:0] addr, input logic [31:0] data);
    drive(d, 1'b1, 1'b1, addr, data);
    sample();
    advance();
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] alt_addr [4] = '{32'h0000_0000, 32'h0000_8000, 32'h0000_0004, 32'h0000_8004};
  logic [31:0] alt_data [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hCAFE_F00D};

  initial begin
    logic [5:0]  gpat, rpat;
    logic [4:0]  spat, opat;
    logic [31:0] adata [6];
    int          max_o;
    logic [31:0] r;

    rst_i = 1'b1;
    for (int b = 0; b < 4; b++) begin bgnt[b] = 1'b1; hold[b] = 1'b0; inj[b] = 1'b0; end
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
      mon_en[d] = 1'b1; prev_gnt[d] = 1'b0;
    end

    // Reset state, and combinational request path live during reset
    sample();
    check("rst_outstanding0", d0_out, 0);
    check("rst_outstanding1", d1_out, 0);
    check("rst_rvalid", d0_mresp.rvalid, 0);
    check("rst_rdata", d0_mresp.rdata, 0);
    check("rst_order_err", d0_err, 0);
    advance();
    drive(0, 1'b1, 1'b0, 32'h0000_8000, 32'h0);
    #1;
    check("rst_gnt_follows", d0_mresp.gnt, 1);
    check("rst_ram1_req_follows", d0_r1.req, 1);
    check("rst_ram0_req_quiet", d0_r0.req, 0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    advance();
    rst_i = 1'b0;

    // Single write + read on bank 0
    drive(0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    sample();
    check("t1_wr_gnt", d0_mresp.gnt, 1);
    check("t1_wr_ram1_quiet", d0_r1.req, 0);
    advance();
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    sample();
    check("t1_rd_gnt", d0_mresp.gnt, 1);
    check("t1_rd_ram1_quiet", d0_r1.req, 0);
    advance();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("t1_rd_rvalid", d0_mresp.rvalid, 1);
    check("t1_rd_rdata", d0_mresp.rdata, 32'hDEAD_BEEF);
    check("t1_ram1_quiet", d0_r1.req, 0);
    advance();

    // Bank select and upper-bit aliasing
    write_word(0, 32'h0000_8004, 32'hCAFE_F00D);
    drive(0, 1'b1, 1'b0, 32'h0000_8004, 32'h0);
    sample();
    check("t2_ram1_req", d0_r1.req, 1);
    check("t2_ram0_quiet", d0_r0.req, 0);
    advance();
    drive(0, 1'b1, 1'b0, 32'h0001_8004, 32'h0);
    sample();
    check("t2_rdata_bank1", d0_mresp.rdata, 32'hCAFE_F00D);
    check("t2_alias_ram1_req", d0_r1.req, 1);
    advance();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("t2_alias_rdata", d0_mresp.rdata, 32'hCAFE_F00D);
    advance();

    // Back-to-back alternating banks
    for (int i = 0; i < 3; i++) write_word(0, alt_addr[i], alt_data[i]);
    sample();
    advance();
    gpat = '0; rpat = '0; max_o = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(0, 1'b1, 1'b0, alt_addr[i], 32'h0);
      else       drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      gpat = {gpat[4:0], d0_mresp.gnt};
      rpat = {rpat[4:0], d0_mresp.rvalid};
      adata[i] = d0_mresp.rdata;
      if (int'(d0_out) > max_o) max_o = int'(d0_out);
      advance();
    end
    check("t3_gnt_pattern", gpat, 6'b111100);
    check("t3_rvalid_pattern", rpat, 6'b011110);
    for (int i = 0; i < 4; i++) check($sformatf("t3_rdata%0d", i), adata[i+1], alt_data[i]);
    check("t3_max_outstanding_le2", (max_o <= 2), 1);

    // Depth-1 instance: held request stalls every other cycle
    spat = '0; opat = '0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
      sample();
      spat = {spat[3:0], d1_mresp.gnt};
      opat = {opat[3:0], d1_out[0]};
      advance();
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    advance();
    check("t4_gnt_pattern", spat, 5'b10101);
    check("t4_outstanding_pattern", opat, 5'b01010);

    // Error: stray bank-1 rvalid with the FIFO empty
    mon_en[0] = 1'b0;
    inj[1] = 1'b1;
    sample();
    check("t5_stray_not_forwarded", d0_mresp.rvalid, 0);
    check("t5_err_not_yet", d0_err, 0);
    advance();
    inj[1] = 1'b0;
    sample();
    check("t5_err_set", d0_err, 1);
    advance();
    sample();
    advance();
    sample();
    check("t5_err_sticky", d0_err, 1);
    advance();

    // Error: non-head bank answers while the FIFO holds a bank-0 entry
    mon_en[1] = 1'b0;
    hold[2] = 1'b1;
    drive(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    sample();
    advance();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    inj[3] = 1'b1;
    sample();
    check("t5b_outstanding", d1_out, 1);
    check("t5b_stray_not_forwarded", d1_mresp.rvalid, 0);
    advance();
    inj[3] = 1'b0;
    hold[2] = 1'b0;
    sample();
    check("t5b_err_set", d1_err, 1);
    advance();

    // Mid-operation asynchronous reset with two transactions in flight
    hold[0] = 1'b1; hold[1] = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    sample();
    advance();
    drive(0, 1'b1, 1'b0, 32'h0000_8000, 32'h0);
    sample();
    advance();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("t6_two_outstanding", d0_out, 2);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_outstanding_cleared", d0_out, 0);
    check("t6_rvalid_low", d0_mresp.rvalid, 0);
    check("t6_err_cleared", d0_err, 0);
    hold[0] = 1'b0; hold[1] = 1'b0;
    advance();
    sample();
    advance();
    rst_i = 1'b0;
    mon_en[0] = 1'b1; mon_en[1] = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h0000_8004, 32'h0);
    sample();
    check("t6_fresh_gnt", d0_mresp.gnt, 1);
    advance();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("t6_fresh_rvalid", d0_mresp.rvalid, 1);
    check("t6_fresh_rdata", d0_mresp.rdata, 32'hCAFE_F00D);
    advance();

    // Randomized traffic on both instances, checked by the monitor
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) bgnt[b] = ($urandom_range(0, 4) != 0);
      for (int d = 0; d < 2; d++) begin
        r = $urandom();
        m_req[d].req   = ($urandom_range(0, 3) != 0);
        m_req[d].we    = r[0];
        m_req[d].be    = r[7:4];
        m_req[d].addr  = $urandom() & 32'hFFFF_803C;
        m_req[d].wdata = $urandom();
      end
      sample();
      advance();
    end
    for (int b = 0; b < 4; b++) bgnt[b] = 1'b1;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      sample();
      advance();
    end
    check("drain_d0", exp_q[0].size(), 0);
    check("drain_d1", exp_q[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_bank_demux.md
# ram_bank_demux

Splits one OBI master port across the two SRAM bank ports of the memory subsystem, with the bank chosen by the top in-range address bit. It tracks outstanding transactions in an in-order bank-ID FIFO. Responses (`rvalid`/`rdata`) are steered back from the bank that owns the oldest transaction. It sits directly upstream of the memory subsystem: its `ram0_req_o`/`ram1_req_o` drive the subsystem's `ram0_req_i`/`ram1_req_i`.

## Interface
- `NUM_BYTES`, default 2**16: total RAM bytes across both banks. `AddrWidth = $clog2(NUM_BYTES)`. The bank select bit is `addr[AddrWidth-1]`.
- `MAX_OUTSTANDING`, default 2: depth of the bank-ID FIFO, i.e. the number of granted transactions not yet answered. Must be at least 1.

Ports (clock and reset first):
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `master_req_i`  in  obi_req_t  master request (`req`, `we`, `be`, `addr`, `wdata`).
- `master_resp_o`  out  obi_resp_t  master response (`gnt`, `rvalid`, `rdata`).
- `ram0_req_o`  out  obi_req_t  bank 0 request.
- `ram0_resp_i`  in  obi_resp_t  bank 0 response.
- `ram1_req_o`  out  obi_req_t  bank 1 request.
- `ram1_resp_i`  in  obi_resp_t  bank 1 response.
- `outstanding_o`  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy.
- `order_err_o`  out  1  sticky; set on an unexpected response.

## Operation
- `sel = master_req_i.addr[AddrWidth-1]`. Address bits at `AddrWidth` and above are ignored (aliasing).
- `full = (count == MAX_OUTSTANDING)`.
- Request path (combinational):
  - `ramX_req_o.req = master_req_i.req & (sel==X) & ~full`.
  - `we`, `be`, `addr` and `wdata` are forwarded unmodified to both banks.
  - `master_resp_o.gnt = master_req_i.req & ~full & ramSEL_resp_i.gnt`.
- Grant: when `master_resp_o.gnt` is high, `sel` is pushed into the FIFO tail. Reads and writes both occupy a slot, because both receive `rvalid`.
- Response path: `head` is the oldest FIFO entry.
  - `master_resp_o.rvalid = ~empty & ramHEAD_resp_i.rvalid`.
  - `master_resp_o.rdata = ramHEAD_resp_i.rdata` when `rvalid` is high, else 32'h0.
  - The FIFO pops when `master_resp_o.rvalid` is high.
- Error: `order_err_o` sets (sticky until reset) in either case:
  - the non-head bank asserts `rvalid` while the FIFO is non-empty;
  - any bank asserts `rvalid` while the FIFO is empty.
  - The offending response is dropped and is not forwarded.
- FIFO: circular buffer of 1-bit entries with separate read and write pointers that wrap at `MAX_OUTSTANDING`, plus an occupancy counter.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push is impossible when full, because `gnt` is gated.
- No bypass: a pop in the same cycle does not permit a grant while full.

## Timing
- Reset values, held while `rst_i` is high: count 0, pointers 0, `order_err_o` 0, `outstanding_o` 0, `master_resp_o.rvalid` 0, `master_resp_o.rdata` 0.
- Combinational outputs (`gnt`, `ramX_req_o`) follow the inputs during reset. `full` is 0 during reset.
- Request path latency: 0 cycles (master to bank).
- Response path latency: 0 cycles (bank `rvalid` to master `rvalid`). Total read latency equals the bank latency: 1 cycle for the memory subsystem.
- With `MAX_OUTSTANDING >= 2` and 1-cycle banks, throughput is one transaction per cycle, including alternating banks. With `MAX_OUTSTANDING = 1`, throughput is one per 2 cycles.
- `outstanding_o` reflects the registered count. It updates one cycle after a grant or response.
- Reset mid-operation: FIFO contents are discarded. A bank `rvalid` arriving after reset release with an empty FIFO sets `order_err_o`. Banks must be reset together with this block.

## Test plan
- **Single read, bank 0.** Write addr 0x0000_0010 with data 0xDEADBEEF, then read it back. Required response: `gnt` in the same cycle, `rvalid` one cycle later, `rdata` 0xDEADBEEF, `ram1_req_o.req` never high.
- **Bank select.** Read addr 0x0000_8004 (bit 15 set with the default `NUM_BYTES`). Required response: only `ram1_req_o.req` asserts, and `rdata` comes from bank 1. Then read addr 0x0001_8004: it aliases to the same bank 1 word.
- **Back-to-back alternating.** Issue reads to 0x0, 0x8000, 0x4, 0x8004 on consecutive cycles. Required response: 4 grants in 4 cycles, 4 `rvalid`s on cycles 2-5 carrying the correct per-bank data in order, `outstanding_o` never above 2.
- **Full stall.** Set `MAX_OUTSTANDING=1` and hold `req` for 3 transactions. Required response: `gnt` pattern 1,0,1,0,1 and `outstanding_o` toggling 1/0.
- **Error injection.** Use a stub bank and raise `ram1_resp_i.rvalid` with the FIFO empty. Required response: `order_err_o` goes to 1 the next cycle and stays high, and `master_resp_o.rvalid` stays 0.
- **Mid-operation reset.** Assert `rst_i` asynchronously with 2 outstanding transactions. Required response: `outstanding_o` is 0 immediately, `master_resp_o.rvalid` is 0, and after release a fresh read completes normally.
